// File: rtl/branch_resolve_if.sv
// branch_resolve_if: ID/EX branch inputs and redirect/statistics outputs of branch_resolve
interface branch_resolve_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic N_flag, Z_flag, V_flag;
    logic id_valid, id_is_b, id_is_br;
    logic [2:0] id_ccc;
    logic [8:0] id_imm9;
    logic [WIDTH-1:0] id_pc_plus2, id_rs_data;
    logic ex_valid, ex_writes_flags;
    logic stall, redirect, flush_ifid;
    logic [WIDTH-1:0] target;
    logic [CNT_W-1:0] br_cnt, taken_cnt;
    modport master (
        output N_flag, Z_flag, V_flag, id_valid, id_is_b, id_is_br, id_ccc, id_imm9,
               id_pc_plus2, id_rs_data, ex_valid, ex_writes_flags,
        input  stall, redirect, target, flush_ifid, br_cnt, taken_cnt
    );
    modport slave (
        input  N_flag, Z_flag, V_flag, id_valid, id_is_b, id_is_br, id_ccc, id_imm9,
               id_pc_plus2, id_rs_data, ex_valid, ex_writes_flags,
        output stall, redirect, target, flush_ifid, br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch resolution with flag-hazard stall, registered redirect and saturating statistics
module branch_resolve #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    branch_resolve_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state;
    logic br_req, resolve, taken;
    logic [7:0] cond;
    logic [WIDTH-1:0] dest;
    always_comb begin
        br_req = bus.id_valid & (bus.id_is_b | bus.id_is_br) & ~bus.redirect;
        bus.stall = rst_n & (state == IDLE) & br_req & bus.ex_valid & bus.ex_writes_flags & (bus.id_ccc != 3'b111);
        resolve = (state == HOLD) | (br_req & ~bus.stall);
        // indexed by ccc: ALW, OVFL, LTE, GTE, LT, GT, EQ, NE
        cond = {1'b1, bus.V_flag, bus.N_flag | bus.Z_flag, bus.Z_flag | ~bus.N_flag,
                bus.N_flag, ~bus.Z_flag & ~bus.N_flag, bus.Z_flag, ~bus.Z_flag};
        taken = resolve & cond[bus.id_ccc];
        dest = bus.id_is_br ? bus.id_rs_data
                            : bus.id_pc_plus2 + {{(WIDTH-10){bus.id_imm9[8]}}, bus.id_imm9, 1'b0};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bus.redirect <= 1'b0;
            bus.flush_ifid <= 1'b0;
            bus.target <= '0;
            bus.br_cnt <= '0;
            bus.taken_cnt <= '0;
        end else begin
            state <= bus.stall ? HOLD : IDLE;
            bus.redirect <= taken;
            bus.flush_ifid <= taken;
            if (taken) bus.target <= dest;
            if (resolve && !(&bus.br_cnt)) bus.br_cnt <= bus.br_cnt + CNT_W'(1);
            if (taken && !(&bus.taken_cnt)) bus.taken_cnt <= bus.taken_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed stimulus checked against a behavioural model and hand-computed literals
module tb_branch_resolve;
    logic clk = 1'b0;
    logic rst_n;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    branch_resolve_if #(.WIDTH(16), .CNT_W(16)) b();
    branch_resolve_if #(.WIDTH(16), .CNT_W(4)) sb();
    branch_resolve #(.WIDTH(16), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    branch_resolve #(.WIDTH(16), .CNT_W(4)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(sb));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model of the main instance
    bit m_hold, m_red;
    logic [15:0] m_tgt;
    int m_br, m_tk;
    function automatic bit cond_met(input logic [2:0] c, input bit n, input bit z, input bit v);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction
    function automatic bit m_req();
        return b.id_valid && (b.id_is_b || b.id_is_br) && !m_red;
    endfunction
    function automatic bit m_stall();
        return rst_n && !m_hold && m_req() && b.ex_valid && b.ex_writes_flags && b.id_ccc != 3'd7;
    endfunction
    function automatic bit m_resolve();
        return m_hold || (m_req() && !m_stall());
    endfunction
    function automatic bit m_taken();
        return m_resolve() && cond_met(b.id_ccc, b.N_flag, b.Z_flag, b.V_flag);
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold <= 1'b0;
            m_red <= 1'b0;
            m_tgt <= '0;
            m_br <= 0;
            m_tk <= 0;
        end else begin
            m_hold <= m_stall();
            m_red <= m_taken();
            if (m_taken())
                m_tgt <= b.id_is_br ? b.id_rs_data
                                    : 16'(int'(b.id_pc_plus2) + 2 * int'($signed(b.id_imm9)));
            if (m_resolve() && m_br < 65535) m_br <= m_br + 1;
            if (m_taken() && m_tk < 65535) m_tk <= m_tk + 1;
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", b.stall, m_stall());
            check("redirect", b.redirect, m_red);
            check("flush_ifid", b.flush_ifid, m_red);
            check("target", b.target, m_tgt);
            check("br_cnt", b.br_cnt, m_br);
            check("taken_cnt", b.taken_cnt, m_tk);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        b.id_valid = 0; b.id_is_b = 0; b.id_is_br = 0; b.id_ccc = 0; b.id_imm9 = 0;
        b.id_pc_plus2 = 0; b.id_rs_data = 0; b.ex_valid = 0; b.ex_writes_flags = 0;
    endtask
    task automatic drive_b(input logic br, input logic [2:0] ccc, input logic [8:0] imm,
                           input logic [15:0] pc, input logic [15:0] rs, input logic exw);
        b.id_valid = 1; b.id_is_b = ~br; b.id_is_br = br; b.id_ccc = ccc; b.id_imm9 = imm;
        b.id_pc_plus2 = pc; b.id_rs_data = rs; b.ex_valid = exw; b.ex_writes_flags = exw;
    endtask

    initial begin
        idle();
        b.N_flag = 0; b.Z_flag = 0; b.V_flag = 0;
        sb.N_flag = 0; sb.Z_flag = 0; sb.V_flag = 0; sb.id_valid = 0; sb.id_is_b = 0;
        sb.id_is_br = 0; sb.id_ccc = 0; sb.id_imm9 = 0; sb.id_pc_plus2 = 0; sb.id_rs_data = 0;
        sb.ex_valid = 0; sb.ex_writes_flags = 0;
        rst_n = 0;
        repeat (2) step();
        check("rst stall", b.stall, 0);
        check("rst redirect", b.redirect, 0);
        check("rst target", b.target, 0);
        check("rst flush", b.flush_ifid, 0);
        check("rst br_cnt", b.br_cnt, 0);
        check("rst taken_cnt", b.taken_cnt, 0);
        rst_n = 1;
        chk_en = 1;
        step();
        // B EQ taken, offset -2 words
        b.Z_flag = 1;
        drive_b(0, 3'd1, 9'h1FE, 16'h0010, 16'h0000, 0);
        #1 check("t1 stall", b.stall, 0);
        step();
        check("t1 redirect", b.redirect, 1);
        check("t1 flush", b.flush_ifid, 1);
        check("t1 target", b.target, 16'h000C);
        check("t1 br_cnt", b.br_cnt, 1);
        check("t1 taken_cnt", b.taken_cnt, 1);
        idle();
        step();
        // B GT behind a flag writer that sets N
        b.Z_flag = 0; b.N_flag = 0;
        drive_b(0, 3'd2, 9'h004, 16'h0100, 16'h0000, 1);
        #1 check("t2 stall", b.stall, 1);
        step();
        b.N_flag = 1;
        #1 check("t2 hold stall", b.stall, 0);
        step();
        check("t2 redirect", b.redirect, 0);
        check("t2 br_cnt", b.br_cnt, 2);
        check("t2 taken_cnt", b.taken_cnt, 1);
        idle();
        step();
        // BR always: no stall despite flag writer
        drive_b(1, 3'd7, 9'h000, 16'h0000, 16'hBEEF, 1);
        #1 check("t3 stall", b.stall, 0);
        step();
        check("t3 redirect", b.redirect, 1);
        check("t3 target", b.target, 16'hBEEF);
        check("t3 br_cnt", b.br_cnt, 3);
        // wrong-path branch during redirect cycle
        b.Z_flag = 1;
        drive_b(0, 3'd1, 9'h010, 16'h0200, 16'h0000, 1);
        #1 check("t4 stall", b.stall, 0);
        step();
        check("t4 redirect", b.redirect, 0);
        check("t4 target", b.target, 16'hBEEF);
        check("t4 br_cnt", b.br_cnt, 3);
        check("t4 taken_cnt", b.taken_cnt, 2);
        idle();
        step();
        // target wraps modulo 2^16
        drive_b(0, 3'd7, 9'h002, 16'hFFFE, 16'h0000, 0);
        step();
        check("t5 redirect", b.redirect, 1);
        check("t5 target", b.target, 16'h0002);
        check("t5 br_cnt", b.br_cnt, 4);
        idle();
        step();
        // back-to-back not-taken NE branches
        drive_b(0, 3'd0, 9'h001, 16'h0300, 16'h0000, 0);
        repeat (3) step();
        check("b2b br_cnt", b.br_cnt, 7);
        check("b2b taken_cnt", b.taken_cnt, 3);
        check("b2b redirect", b.redirect, 0);
        idle();
        step();
        // async reset while in HOLD
        b.Z_flag = 0;
        drive_b(0, 3'd1, 9'h001, 16'h0400, 16'h0000, 1);
        #1 check("t6 stall", b.stall, 1);
        step();
        #1 rst_n = 0;
        #1;
        check("t6 rst stall", b.stall, 0);
        check("t6 rst redirect", b.redirect, 0);
        check("t6 rst target", b.target, 0);
        check("t6 rst br_cnt", b.br_cnt, 0);
        check("t6 rst taken_cnt", b.taken_cnt, 0);
        idle();
        step();
        rst_n = 1;
        repeat (2) step();
        check("t6 post redirect", b.redirect, 0);
        check("t6 post br_cnt", b.br_cnt, 0);
        // saturation on a narrow-counter instance: taken B every other cycle
        sb.id_valid = 1; sb.id_is_b = 1; sb.id_ccc = 3'd7; sb.id_pc_plus2 = 16'h0040;
        repeat (10) step();
        check("sat mid br_cnt", sb.br_cnt, 5);
        check("sat mid taken_cnt", sb.taken_cnt, 5);
        repeat (30) step();
        check("sat br_cnt", sb.br_cnt, 4'hF);
        check("sat taken_cnt", sb.taken_cnt, 4'hF);
        sb.id_valid = 0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumes N_flag/Z_flag/V_flag from the flag register in the ID stage of the 16-bit pipeline.
- Evaluates the 3-bit condition code of B (PC-relative) and BR (register) instructions.
- Stalls ID one cycle when the instruction in EX is about to update the flags.
- Issues a registered redirect with target and an IF/ID flush pulse, and keeps saturating branch statistics counters.

Parameters:
WIDTH, 16, datapath/PC width
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low (one clock; asynchronous active-low reset)
N_flag  input  1  negative flag from flag register
Z_flag  input  1  zero flag from flag register
V_flag  input  1  overflow flag from flag register
id_valid  input  1  ID holds a valid instruction
id_is_b  input  1  ID instruction is B (PC-relative)
id_is_br  input  1  ID instruction is BR (register target)
id_ccc  input  3  condition code
id_imm9  input  9  signed word offset for B
id_pc_plus2  input  WIDTH  PC+2 of ID instruction
id_rs_data  input  WIDTH  register target for BR
ex_valid  input  1  EX holds a valid instruction
ex_writes_flags  input  1  EX instruction updates flags at end of this cycle
stall  output  1  hold PC and IF/ID this cycle (combinational)
redirect  output  1  registered: fetch from target this cycle
target  output  WIDTH  registered redirect address
flush_ifid  output  1  registered: squash IF/ID contents (equals redirect)
br_cnt  output  CNT_W  branches resolved, saturating
taken_cnt  output  CNT_W  branches taken, saturating

Behaviour:
- Reset values: stall=0, redirect=0, target=0, flush_ifid=0, br_cnt=0, taken_cnt=0, state=IDLE. Reset is asynchronous and may occur mid-stall; everything clears and no redirect is issued.
- br_req = id_valid & (id_is_b | id_is_br) & ~redirect. ID contents during a redirect cycle are wrong-path and are ignored.
- If id_is_b and id_is_br are both 1, the instruction is treated as BR.
- Conditions:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | (~Z & ~N)
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 always
- State machine:
  - IDLE: if br_req & ex_valid & ex_writes_flags & (id_ccc != 111), assert stall=1 and go to HOLD; do not resolve. Otherwise, if br_req, resolve this cycle.
  - HOLD: stall=0. Flags now reflect the EX writer. Resolve the held branch unconditionally, ignoring ex_writes_flags because EX holds a bubble. Return to IDLE.
- ID inputs are held stable by the pipeline while stall=1.
- Resolve cycle t computes the result. At edge t+1:
  - redirect <= taken
  - flush_ifid <= taken
  - target <= B ? id_pc_plus2 + (sext(id_imm9) << 1) : id_rs_data
  - Arithmetic is WIDTH bits, wrap-around modulo 2^WIDTH.
- redirect and flush_ifid are single-cycle pulses. target holds its last value when redirect=0.
- A not-taken branch produces no redirect. Only the counters change.
- Counters:
  - br_cnt increments once per resolved branch.
  - taken_cnt increments once per taken branch.
  - Both hold at all ones (saturate).
  - A stalled branch counts once, at resolution.
- Back-to-back not-taken branches resolve one per cycle with no bubble.
- A branch in ID during a redirect cycle is never counted or stalled.

Test Plan:
1. B, ccc=001, Z=1, pc_plus2=0x0010, imm9=0x1FE (-2), no EX writer -> stall=0; next cycle redirect=1, flush_ifid=1, target=0x000C; br_cnt=1, taken_cnt=1.
2. B, ccc=010, Z=0, N=0, EX writes flags that set N=1 -> cycle t stall=1; cycle t+1 stall=0, resolves with N=1, no redirect; br_cnt=1, taken_cnt=0.
3. BR, ccc=111, rs_data=0xBEEF, ex_writes_flags=1 -> no stall; next cycle redirect=1, target=0xBEEF.
4. Taken branch followed by a branch in ID during the redirect cycle -> second branch ignored: no stall, no second redirect, br_cnt increments only once.
5. B at pc_plus2=0xFFFE, imm9=0x002 -> target=0x0002 (wrap).
6. Preload 0xFFFF branches (force or run), then one more taken branch -> br_cnt and taken_cnt remain 0xFFFF. Also assert rst_n low during HOLD -> stall, redirect and counters immediately 0, no redirect after release.
